// File: rtl/cube_data_stream_buffer.sv
// Cube state stream buffer: assembles 120-bit frames from narrow beats, checks framing,
// queues complete frames in a FIFO and presents the head as a 48-element fixed-point tensor.
module cube_data_stream_buffer #(
  parameter int unsigned DATA_LEN = 16,
  parameter int unsigned DATA_DEC = 8,
  parameter int unsigned BEAT_W   = 30,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  input  logic                         s_valid_i,
  output logic                         s_ready_o,
  input  logic [BEAT_W-1:0]            s_data_i,
  input  logic                         s_last_i,
  output logic                         m_valid_o,
  input  logic                         m_ready_i,
  output logic [48*DATA_LEN-1:0]       m_data_o,
  output logic [$clog2(DEPTH+1)-1:0]   level_o,
  output logic                         err_o
);

  localparam int unsigned FrameW = 120;
  localparam int unsigned Beats  = FrameW / BEAT_W;
  localparam int unsigned BcntW  = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned PtrW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LvlW   = $clog2(DEPTH + 1);
  localparam logic [BcntW-1:0] LastBeat = BcntW'(Beats - 1);

  typedef enum logic [0:0] {StRecv, StDrop} state_e;

  state_e                state_q, state_d;
  logic [BcntW-1:0]      bcnt_q, bcnt_d;
  logic [FrameW-1:0]     asm_q, asm_d;
  logic [FrameW-1:0]     push_word;
  logic [FrameW-1:0]     mem_q [DEPTH];
  logic [PtrW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LvlW-1:0]       level_q, level_d;
  logic                  err_q, err_d;
  logic                  accept, push, pop;
  logic [FrameW-1:0]     head;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Ready depends on registered state only; the final beat is held off while the FIFO is full.
  assign s_ready_o = (state_q == StDrop) || (bcnt_q != LastBeat) || (level_q < LvlW'(DEPTH));
  assign m_valid_o = (level_q != '0);
  assign level_o   = level_q;
  assign err_o     = err_q;
  assign accept    = s_valid_i && s_ready_o;
  assign pop       = m_valid_o && m_ready_i && !clear_i;

  // Assembler FSM: beat slotting, framing checks and push decision.
  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    asm_d     = asm_q;
    push      = 1'b0;
    err_d     = 1'b0;
    push_word = asm_q;
    push_word[(Beats-1)*BEAT_W +: BEAT_W] = s_data_i;
    if (clear_i) begin
      state_d = StRecv;
      bcnt_d  = '0;
    end else if (accept) begin
      unique case (state_q)
        StRecv: begin
          asm_d[bcnt_q*BEAT_W +: BEAT_W] = s_data_i;
          if (bcnt_q != LastBeat) begin
            if (s_last_i) begin
              err_d  = 1'b1;
              bcnt_d = '0;
            end else begin
              bcnt_d = bcnt_q + 1'b1;
            end
          end else begin
            bcnt_d = '0;
            if (s_last_i) begin
              push = 1'b1;
            end else begin
              err_d   = 1'b1;
              state_d = StDrop;
            end
          end
        end
        StDrop: begin
          if (s_last_i) begin
            state_d = StRecv;
            bcnt_d  = '0;
          end
        end
        default: state_d = StRecv;
      endcase
    end
  end

  // FIFO pointer and occupancy next-state.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (clear_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (push) wptr_d = ptr_inc(wptr_q);
      if (pop)  rptr_d = ptr_inc(rptr_q);
      if (push && !pop)      level_d = level_q + 1'b1;
      else if (!push && pop) level_d = level_q - 1'b1;
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StRecv;
      bcnt_q  <= '0;
      asm_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      asm_q   <= asm_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      err_q   <= err_d;
    end
  end

  // Frame storage; contents are masked at the output while empty, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= push_word;
  end

  assign head = m_valid_o ? mem_q[rptr_q] : '0;

  // Unpack head entry: each field lands with its LSB at bit DATA_DEC of its element.
  always_comb begin
    m_data_o = '0;
    for (int i = 0; i < 12; i++) begin
      m_data_o[i*DATA_LEN + DATA_DEC +: 3]        = head[3*i +: 3];
      m_data_o[(12+i)*DATA_LEN + DATA_DEC +: 2]   = head[36 + 2*i +: 2];
      m_data_o[(24+i)*DATA_LEN + DATA_DEC +: 4]   = head[60 + 4*i +: 4];
      m_data_o[(36+i)*DATA_LEN + DATA_DEC]        = head[108 + i];
    end
  end

endmodule

// File: tb/tb_cube_data_stream_buffer.sv
// Scoreboard bench for cube_data_stream_buffer: driver pushes expected frames, monitor pops
// and compares against a tensor model built from the field layout.
module tb_cube_data_stream_buffer;

  localparam int unsigned DL = 16;
  localparam int unsigned DD = 8;
  localparam int unsigned BW = 30;
  localparam int unsigned DP = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           clear = 1'b0;
  logic           s_valid = 1'b0;
  logic           s_ready;
  logic [BW-1:0]  s_data = '0;
  logic           s_last = 1'b0;
  logic           m_valid;
  logic           m_ready = 1'b0;
  logic [48*DL-1:0] m_data;
  logic [2:0]     level;
  logic           err;

  int total = 0;
  int bad = 0;
  int err_seen = 0;
  int cyc = 0;
  int pushed = 0;
  int popped = 0;
  logic [119:0] sb[$];

  cube_data_stream_buffer #(
    .DATA_LEN(DL), .DATA_DEC(DD), .BEAT_W(BW), .DEPTH(DP)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data), .s_last_i(s_last),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data),
    .level_o(level), .err_o(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (err === 1'b1) err_seen++;

  function automatic logic [48*DL-1:0] tensor_of(input logic [119:0] f);
    logic [48*DL-1:0] t;
    int unsigned v;
    t = '0;
    for (int e = 0; e < 48; e++) begin
      int i;
      i = e % 12;
      case (e / 12)
        0:       v = 32'(f >> (3 * i)) & 32'd7;
        1:       v = 32'(f >> (36 + 2 * i)) & 32'd3;
        2:       v = 32'(f >> (60 + 4 * i)) & 32'd15;
        default: v = 32'(f >> (108 + i)) & 32'd1;
      endcase
      t[e*DL +: DL] = 16'(v << DD);
    end
    return t;
  endfunction

  function automatic logic [119:0] rand_frame();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string name, input logic [48*DL-1:0] act, input logic [48*DL-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: every head consumption is compared with the oldest expected frame.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1 && clear === 1'b0) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_unexpected: got %0h want none", m_data);
      end else begin
        check("pop_data", m_data, tensor_of(sb.pop_front()));
        popped++;
      end
    end
  end

  task automatic send_beat(input logic [BW-1:0] d, input logic l);
    bit done;
    done = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      done = (s_ready === 1'b1);
      @(posedge clk);
      #1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL beat_timeout: got s_ready=0 want 1");
    end
  endtask

  task automatic send_frame(input logic [119:0] f, input bit hold);
    for (int b = 0; b < 4; b++) begin
      m_ready = hold && (b == 3);
      send_beat(f[b*BW +: BW], b == 3);
    end
    sb.push_back(f);
    pushed++;
  endtask

  task automatic idle();
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    m_ready = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      @(posedge clk);
      #1;
      done = (level == 0);
    end
    m_ready = 1'b0;
    check("drain_level", 768'(level), 768'(0));
  endtask

  logic [119:0] f;
  logic [48*DL-1:0] exp_t;
  int e0;
  int c0;

  initial begin
    #2 rst_n = 1'b0;
    #5;
    check("rst_s_ready", 768'(s_ready), 768'(1));
    check("rst_m_valid", 768'(m_valid), 768'(0));
    check("rst_level", 768'(level), 768'(0));
    check("rst_err", 768'(err), 768'(0));
    check("rst_m_data", m_data, '0);
    #15 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed frame: corner pos 0, edge pos 11, edge dir 5.
    f = '0;
    f[2:0] = 3'b101;
    f[107:104] = 4'hB;
    f[113] = 1'b1;
    send_frame(f, 1'b0);
    idle();
    check("lat_m_valid", 768'(m_valid), 768'(1));
    check("lat_level", 768'(level), 768'(1));
    exp_t = '0;
    exp_t[0*DL +: DL] = 16'h0500;
    exp_t[35*DL +: DL] = 16'h0B00;
    exp_t[41*DL +: DL] = 16'h0100;
    check("directed_tensor", m_data, exp_t);
    drain();

    // Fill to DEPTH, fifth frame stalls on its final beat until one pop.
    for (int n = 0; n < 4; n++) send_frame(rand_frame(), 1'b0);
    idle();
    check("full_level", 768'(level), 768'(4));
    f = rand_frame();
    for (int b = 0; b < 3; b++) send_beat(f[b*BW +: BW], 1'b0);
    s_data = f[3*BW +: BW];
    s_last = 1'b1;
    @(negedge clk);
    check("full_s_ready", 768'(s_ready), 768'(0));
    @(posedge clk);
    #1;
    @(negedge clk);
    check("full_s_ready2", 768'(s_ready), 768'(0));
    @(posedge clk);
    #1 m_ready = 1'b1;
    @(posedge clk);
    #1 m_ready = 1'b0;
    check("pop_reenable", 768'(s_ready), 768'(1));
    check("pop_level", 768'(level), 768'(3));
    @(posedge clk);
    #1;
    sb.push_back(f);
    pushed++;
    idle();
    check("fifth_level", 768'(level), 768'(4));
    drain();

    // Early last on beat 1.
    e0 = err_seen;
    send_beat(BW'($urandom), 1'b0);
    send_beat(BW'($urandom), 1'b1);
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("early_err", 768'(err_seen - e0), 768'(1));
    check("early_level", 768'(level), 768'(0));
    send_frame(rand_frame(), 1'b0);
    idle();
    check("early_next_level", 768'(level), 768'(1));
    drain();

    // Missing last on beat 3, then two junk beats.
    e0 = err_seen;
    for (int b = 0; b < 4; b++) send_beat(BW'($urandom), 1'b0);
    send_beat(BW'($urandom), 1'b0);
    send_beat(BW'($urandom), 1'b1);
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("miss_err", 768'(err_seen - e0), 768'(1));
    check("miss_level", 768'(level), 768'(0));
    send_frame(rand_frame(), 1'b0);
    idle();
    check("miss_next_level", 768'(level), 768'(1));
    drain();

    // Clear with two queued frames and a half-received one.
    send_frame(rand_frame(), 1'b0);
    send_frame(rand_frame(), 1'b0);
    f = rand_frame();
    send_beat(f[0 +: BW], 1'b0);
    send_beat(f[BW +: BW], 1'b0);
    check("pre_clear_level", 768'(level), 768'(2));
    e0 = err_seen;
    s_valid = 1'b1;
    s_data = f[2*BW +: BW];
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    idle();
    sb.delete();
    check("clr_level", 768'(level), 768'(0));
    check("clr_m_valid", 768'(m_valid), 768'(0));
    check("clr_m_data", m_data, '0);
    @(posedge clk);
    #1;
    check("clr_err", 768'(err_seen - e0), 768'(0));
    send_frame(rand_frame(), 1'b0);
    idle();
    check("clr_next_level", 768'(level), 768'(1));

    // Streaming: push and pop coincide on every final beat, level holds at 1.
    c0 = cyc;
    for (int n = 0; n < 20; n++) begin
      send_frame(rand_frame(), 1'b1);
      check("stream_level", 768'(level), 768'(1));
    end
    idle();
    check("stream_cycles", 768'(cyc - c0), 768'(80));
    drain();
    check("sb_empty", 768'(sb.size()), 768'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cube_data_stream_buffer.md
# cube_data_stream_buffer

Parametrised successor to the single-shot cube loader. It receives a packed 120-bit cube state as a stream of narrow beats over a valid/ready handshake and checks the framing. Complete frames are queued in a DEPTH-entry FIFO, and the head entry is presented as the 48-element fixed-point tensor (shape 4,3,4) that feeds the network input layer. Downstream consumes it with its own valid/ready handshake.

## Interface
- DATA_LEN, default 16: width of one fixed-point element.
- DATA_DEC, default 8: fractional bits per element. Requires DATA_LEN - DATA_DEC >= 5.
- BEAT_W, default 30: input beat width. Must divide 120. BEATS = 120/BEAT_W.
- DEPTH, default 4: number of FIFO entries, >= 1. Entries are stored packed at 120 bits each.
- clk, input, 1: the single clock. All state changes on its rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- clear, input, 1: synchronous flush.
- s_valid, input, 1: input beat valid.
- s_ready, output, 1: input beat accepted when s_valid && s_ready.
- s_data, input, BEAT_W: input beat. Beat 0 carries packed bits [BEAT_W-1:0]; beats are sent LSB-first.
- s_last, input, 1: marks the final beat of a frame.
- m_valid, output, 1: head entry available.
- m_ready, input, 1: head entry consumed when m_valid && m_ready.
- m_data, output, 48*DATA_LEN: unpacked head entry.
- level, output, clog2(DEPTH+1): number of entries currently held.
- err, output, 1: one-cycle pulse when a frame is dropped for bad framing.

## Operation
- Packed frame layout, for i = 0..11:
  - corner position i: bits [3i +: 3]
  - corner direction i: bits [36+2i +: 2]
  - edge position i: bits [60+4i +: 4]
  - edge direction i: bits [108+i]
- Unpack rule: element e occupies m_data[e*DATA_LEN +: DATA_LEN]. Each field value is placed with its LSB at bit DATA_DEC of its element, and every other bit of the element is 0.
  - Corner position i maps to e = i.
  - Corner direction i maps to e = 12+i.
  - Edge position i maps to e = 24+i.
  - Edge direction i maps to e = 36+i.
- m_data is wiring-only from the head storage entry. It is all-zero whenever level == 0.
- Assembler FSM, with beat counter bcnt running 0..BEATS-1:
  - RECV: each accepted beat is written into slot bcnt.
    - Accepted with bcnt < BEATS-1 and s_last=0: bcnt increments.
    - Accepted with bcnt < BEATS-1 and s_last=1 (early last): frame discarded, err pulses, bcnt returns to 0, state stays RECV.
    - Accepted with bcnt == BEATS-1 and s_last=1: the completed 120-bit word is pushed into the FIFO and bcnt returns to 0.
    - Accepted with bcnt == BEATS-1 and s_last=0 (missing last): frame discarded, err pulses, state goes to DROP.
  - DROP: beats are accepted and discarded. The first accepted beat with s_last=1 returns the FSM to RECV with bcnt=0; that beat produces no err.
  - With BEATS == 1, a beat with s_last=0 is a missing-last case and goes to DROP.
- s_ready = (state == DROP) || (bcnt != BEATS-1) || (level < DEPTH). It is a function of registered state only, with no combinational path from m_ready.
- FIFO: circular buffer with wrapping write and read pointers.
  - Push and pop in the same cycle leave level unchanged.
  - A push is impossible when level == DEPTH, because s_ready holds the final beat off.
- clear takes priority over all other activity. It empties the FIFO (level 0, pointers 0), sets the FSM to RECV with bcnt=0, and discards any partial frame. No err is raised, and beats presented in the same cycle are ignored.

## Timing
- Reset, asynchronous on rst_n low:
  - level=0, m_valid=0, m_data=0, err=0.
  - FSM=RECV, bcnt=0.
  - s_ready=1 immediately, since DEPTH >= 1.
  - Reset mid-frame discards the partial frame and all queued entries.
- Latency: the final beat is accepted at edge N. m_valid is high and m_data valid in the cycle after edge N, provided the FIFO is not already holding entries ahead of it.
- A pop at edge N exposes the next entry, or zeros, after edge N.
- Throughput: one beat per cycle. One frame per BEATS cycles is sustained when m_ready is held high.
- err is high for exactly the cycle after the offending beat's acceptance edge.
- m_valid == (level != 0). It is registered and never depends combinationally on inputs.

## Test plan
Bench configuration: DATA_LEN=16, DATA_DEC=8, BEAT_W=30, DEPTH=4.
- Reset, then one frame with corner position 0 = 3'b101, edge position 11 = 4'hB, edge direction 5 = 1, all other bits 0, sent over 4 beats with s_last on beat 3. Required:
  - m_valid rises the cycle after beat 3.
  - Element 0 = 16'h0500, element 35 = 16'h0B00, element 41 = 16'h0100, all other elements 0.
  - level=1.
- Five frames with m_ready=0. Required:
  - level reaches 4.
  - s_ready drops while bcnt=3 of the fifth frame.
  - One pop re-enables s_ready the next cycle, and the fifth frame is accepted.
  - Frames pop out in order, values intact across pointer wrap.
- s_last asserted on beat 1. Required: err pulses once, level unchanged. The next 4-beat frame is received correctly.
- Beat 3 sent without s_last, followed by 2 junk beats with s_last on the second. Required: one err pulse, no push. FSM returns to RECV and the following frame is received correctly.
- With level=2 and a frame half-received, assert clear for one cycle while s_valid=1. Required: level=0, m_valid=0, m_data=0, no err. A subsequent full frame yields level=1.
- Continuous stream with m_ready=1 and the FIFO holding 1 entry, so that a push and a pop coincide on the same edge. Required: level stays 1 and no frame is lost or duplicated across 20 frames.
